rom_loader: RTL and testbench
=============================

// Module: rom_loader
// PURPOSE
//  Writer side of the on-chip ROM image: takes the HPS ioctl byte stream (one file index) and
//  writes it into the RAM holding a ROM image, paced by the target memory's clock enable.
//  Sits between the ioctl download port and the RAM's write port; core stays in reset until done.
// PARAMETERS
//  KB     16     image size in KiB; memory address width AW = $clog2(KB*1024)
//  INDEX  8'd0   ioctl_index value this loader accepts; other indexes are ignored
// PORTS
//  clock          in   1    system clock
//  reset          in   1    synchronous, active-high reset
//  ce             in   1    target memory clock enable; a write is issued only when ce=1
//  ioctl_download in   1    high for the whole transfer
//  ioctl_index    in   8    file index of the current transfer
//  ioctl_wr       in   1    one-cycle strobe: ioctl_addr/ioctl_dout valid
//  ioctl_addr     in   25   byte address within the file
//  ioctl_dout     in   8    data byte
//  ioctl_wait     out  1    back-pressure to HPS; high while the byte buffer is full
//  mem_we         out  1    one-cycle write strobe, coincident with ce
//  mem_a          out  AW   write address
//  mem_d          out  8    write data
//  busy           out  1    high from accepted download start until DONE/ERROR
//  done           out  1    image fully written, sticky until next accepted download or reset
//  error          out  1    address overflow or protocol violation, sticky likewise
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, buffer empty; an interrupted write is never issued.
//  - FSM IDLE -> LOAD on ioctl_download=1 with ioctl_index==INDEX (clears done/error, busy=1).
//  - LOAD: ioctl_wr with buffer empty captures {addr[AW-1:0],dout}; buffer full -> ioctl_wait=1
//    from the next cycle. First cycle with ce=1 and buffer full: mem_we=1 for that cycle,
//    buffer empties, ioctl_wait drops the following cycle. Min latency wr->mem_we: 1 cycle.
//  - ioctl_wr and drain in the same cycle: drain the old byte, capture the new one; buffer stays full.
//  - ioctl_wr while buffer full (HPS ignored wait): byte dropped, error=1, load continues.
//  - ioctl_addr >= KB*1024: byte dropped (no mem_we), error=1; no wrap-around into low memory.
//  - LOAD -> FLUSH on ioctl_download falling; FLUSH waits for buffer drain (next ce), then
//    -> DONE (done=1, busy=0), or -> ERROR (error=1, busy=0) if any error occurred.
//  - DONE/ERROR -> LOAD directly on a new accepted download; other-index downloads never change
//    state or outputs and never assert ioctl_wait.
//  - ioctl_index change mid-LOAD: ignored; index is latched at start.
//  - mem_a/mem_d hold their last value when mem_we=0.
// CONFIGURATION
//  ROM_LOADER_CKSUM_EN defined: extra output cksum[7:0], 8-bit mod-256 sum of every byte
//    actually written (dropped bytes excluded), cleared at accepted download start, frozen
//    in DONE/ERROR, 0 on reset. Not defined: port absent, no adder logic.
// STRUCTURE
//  - Shared package/include zx48_defs.vh: FSM state encoding (IDLE, LOAD, FLUSH, DONE, ERROR),
//    ioctl index constants (ROM image indexes), ioctl address width 25.
//  - One natural sub-module: rom_loader_buf, single-entry byte+address buffer with
//    full flag, load/drain ports and simultaneous load+drain support.
// TESTING
//  1 KB=1, ce=1 always, 1024 back-to-back wr -> 1024 mem_we, RAM == file, done=1, error=0.
//  2 ce every 4th cycle, wr every cycle -> ioctl_wait high between drains, no byte lost/duplicated.
//  3 wr at addr 1024 with KB=1 -> no mem_we, RAM[0] unchanged, error=1 after download end.
//  4 reset asserted with buffer full, ce low -> no mem_we ever, busy/done/error=0, wait=0.
//  5 download with ioctl_index=INDEX+1 -> busy stays 0, no mem_we, ioctl_wait 0.
//  6 CKSUM_EN, bytes 8'hFF,8'h02,8'h10 -> cksum=8'h11; second download restarts from 0.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared definitions for the ROM image loader:
//   - loader FSM state encoding
//   - ioctl file index constants and the ioctl address width
//   - a small helper that says which states may accept a new download
package rom_loader_pkg;

  localparam int IOCTL_AW = 25;

  // File index carried by the main ROM image download
  localparam logic [7:0] IDX_ROM = 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } ld_state_t;

  // A new download is only taken when no transfer is in flight.
  function automatic logic state_accepts_start(input ld_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if
//   HPS ioctl download port as seen by the loader.
//   master : HPS side, drives download/index/wr/addr/dout, receives wait
//   slave  : loader side, the mirror image
interface rom_loader_if;
  import rom_loader_pkg::*;

  logic                ioctl_download;
  logic [7:0]          ioctl_index;
  logic                ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic                ioctl_wait;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait
  );

endinterface

// File: rtl/rom_loader_buf.sv
// rom_loader_buf
//   Single-entry address+byte holding register between the ioctl stream and
//   the RAM write port.
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   load_i            capture addr_i/data_i, buffer becomes full
//   drain_i           current entry consumed, buffer becomes empty
//   addr_i, data_i    entry to capture
//   full_o            entry present
//   addr_o, data_o    held entry; keeps its value after draining
// A load and a drain in the same cycle replace the entry and keep it full.
module rom_loader_buf #(
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    data_i,
  output logic          full_o,
  output logic [AW-1:0] addr_o,
  output logic [7:0]    data_o
);

  logic          full_q, full_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;

endmodule

// File: rtl/rom_loader.sv
// rom_loader
//   Writes one ioctl file (selected by INDEX) into the RAM holding a ROM
//   image. Each accepted byte is parked in a one-entry buffer and written on
//   the next cycle where the memory clock enable ce is high.
// Parameters
//   KB     image size in KiB, write address width AW = $clog2(KB*1024)
//   INDEX  ioctl_index accepted by this loader
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   ce             target memory clock enable
//   ioctl          HPS download port (rom_loader_if.slave)
//   mem_we         one-cycle write strobe, only while ce=1
//   mem_a, mem_d   write address/data, held while mem_we=0
//   busy           transfer in progress
//   done           image written cleanly, sticky until next accepted start
//   error          overflow or wait-ignored write seen, sticky likewise
//   cksum          (ROM_LOADER_CKSUM_EN only) mod-256 sum of bytes written
// Optional feature macro: ROM_LOADER_CKSUM_EN
//
// state  | meaning
// IDLE   | no transfer since reset
// LOAD   | download active, bytes being accepted
// FLUSH  | download ended, waiting for the last buffered byte to be written
// DONE   | image complete without error
// ERROR  | transfer ended, at least one byte was dropped
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         KB    = 16,
  parameter logic [7:0] INDEX = IDX_ROM,
  localparam int        AW    = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  rom_loader_if.slave   ioctl,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [7:0]    mem_d,
  output logic          busy,
  output logic          done,
`ifdef ROM_LOADER_CKSUM_EN
  output logic          error,
  output logic [7:0]    cksum
`else
  output logic          error
`endif
);

  localparam logic [IOCTL_AW-1:0] IMG_BYTES = IOCTL_AW'(KB * 1024);

  ld_state_t     state_q;
  logic          busy_q, done_q, error_q;

  logic          buf_full;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;

  logic          accept;
  logic          in_load;
  logic          drain;
  logic          addr_ok;
  logic          buf_load;
  logic          wr_err;

  // Start needs the index to match only at the moment of acceptance; after
  // that the index bus is not looked at again.
  assign accept  = state_accepts_start(state_q) && ioctl.ioctl_download &&
                   (ioctl.ioctl_index == INDEX);
  assign in_load = (state_q == ST_LOAD);

  // Reset masks the strobe so a write caught by reset is never issued.
  assign drain   = buf_full && ce && !reset &&
                   ((state_q == ST_LOAD) || (state_q == ST_FLUSH));

  // Full-width compare: out-of-range bytes are dropped, never wrapped.
  assign addr_ok  = (ioctl.ioctl_addr < IMG_BYTES);
  assign buf_load = in_load && ioctl.ioctl_wr && addr_ok && (!buf_full || drain);
  assign wr_err   = in_load && ioctl.ioctl_wr && (!addr_ok || (buf_full && !drain));

  rom_loader_buf #(
    .AW(AW)
  ) u_buf (
    .clock  (clock),
    .reset  (reset),
    .load_i (buf_load),
    .drain_i(drain),
    .addr_i (ioctl.ioctl_addr[AW-1:0]),
    .data_i (ioctl.ioctl_dout),
    .full_o (buf_full),
    .addr_o (buf_addr),
    .data_o (buf_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (accept) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wr_err) error_q <= 1'b1;
          if (!ioctl.ioctl_download) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (!buf_full || drain) begin
            state_q <= error_q ? ST_ERROR : ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= !error_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROM_LOADER_CKSUM_EN
  logic [7:0] cksum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cksum_q <= 8'h00;
    end else if (accept) begin
      cksum_q <= 8'h00;
    end else if (drain) begin
      cksum_q <= cksum_q + buf_data;
    end
  end

  assign cksum = cksum_q;
`endif

  assign ioctl.ioctl_wait = buf_full && !reset;
  assign mem_we           = drain;
  assign mem_a            = buf_addr;
  assign mem_d            = buf_data;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int         KB    = 1;
  localparam int         NB    = KB * 1024;
  localparam logic [7:0] IDX   = 8'd0;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic       mem_we;
  logic [9:0] mem_a;
  logic [7:0] mem_d;
  logic       busy, done, error;
`ifdef ROM_LOADER_CKSUM_EN
  logic [7:0] cksum;
`endif

  rom_loader_if bus ();

  rom_loader #(
    .KB   (KB),
    .INDEX(IDX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .ioctl (bus),
    .mem_we(mem_we),
    .mem_a (mem_a),
    .mem_d (mem_d),
    .busy  (busy),
    .done  (done),
`ifdef ROM_LOADER_CKSUM_EN
    .error (error),
    .cksum (cksum)
`else
    .error (error)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Shadow RAM filled from the write port; stamp records which test wrote it.
  logic [7:0] ram   [NB];
  int         stamp [NB];
  int         epoch = 0;
  int         wcount = 0;
  int         wait_cyc = 0;
  int         busy_cyc = 0;

  logic [7:0] file [NB];

  always @(negedge clock) begin
    if (mem_we) begin
      ram[mem_a]   = mem_d;
      stamp[mem_a] = epoch;
      wcount++;
    end
    if (bus.ioctl_wait) wait_cyc++;
    if (busy) busy_cyc++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr       = 1'b0;
    step();
  endtask

  task automatic end_dl();
    int k;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    ce                 = 1'b1;
    k = 0;
    step();
    while (busy && k < 50) begin
      step();
      k++;
    end
    if (busy) check_eq("flush_timeout", int'(busy), 0);
    step();
    step();
  endtask

  // mode 0: ce always high, 1: ce every p-th cycle, 2: ce random
  task automatic send_file(input int n, input int mode, input int p,
                           input bit honor_wait, input bit rand_idx);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 20000) begin
      case (mode)
        0:       ce = 1'b1;
        1:       ce = ((cyc % p) == 0);
        default: ce = 1'($urandom_range(0, 1));
      endcase
      if (rand_idx) bus.ioctl_index = 8'($urandom);
      if (!honor_wait || !bus.ioctl_wait) begin
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'(i);
        bus.ioctl_dout = file[i];
        i++;
      end else begin
        bus.ioctl_wr = 1'b0;
      end
      step();
      cyc++;
    end
    bus.ioctl_wr = 1'b0;
    if (i < n) check_eq("send_timeout", i, n);
  endtask

  task automatic run_clean(input int n, input int mode, input int p,
                           input bit honor_wait, input bit rand_idx, input string tag);
    int w0;
    int bad;
    logic [7:0] sum;
    epoch++;
    w0  = wcount;
    sum = 8'h00;
    for (int i = 0; i < n; i++) sum = sum + file[i];
    start_dl(IDX);
    send_file(n, mode, p, honor_wait, rand_idx);
    end_dl();
    bad = 0;
    for (int i = 0; i < n; i++)
      if (stamp[i] != epoch || ram[i] != file[i]) bad++;
    check_eq({tag, "_wcount"}, wcount - w0, n);
    check_eq({tag, "_ram"}, bad, 0);
    check_eq({tag, "_done"}, int'(done), 1);
    check_eq({tag, "_error"}, int'(error), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
`ifdef ROM_LOADER_CKSUM_EN
    check_eq({tag, "_cksum"}, int'(cksum), int'(sum));
`endif
  endtask

  initial begin
    int w0;
    int wt0;
    int b0;

    reset              = 1'b1;
    ce                 = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;
    for (int i = 0; i < NB; i++) begin
      ram[i]   = 8'h00;
      stamp[i] = -1;
    end
    step();
    step();
    reset = 1'b0;
    step();

    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_error", int'(error), 0);
    check_eq("rst_wait", int'(bus.ioctl_wait), 0);
    check_eq("rst_mem_we", int'(mem_we), 0);
`ifdef ROM_LOADER_CKSUM_EN
    check_eq("rst_cksum", int'(cksum), 0);
`endif

    // Full image, ce always high, back-to-back strobes
    for (int i = 0; i < NB; i++) file[i] = 8'($urandom);
    run_clean(NB, 0, 1, 1'b0, 1'b0, "full");

    // Slow memory: ce every 4th cycle, HPS honouring wait
    for (int i = 0; i < 64; i++) file[i] = 8'($urandom);
    wt0 = wait_cyc;
    run_clean(64, 1, 4, 1'b1, 1'b0, "slow");
    check_eq("slow_wait_seen", int'(wait_cyc - wt0 > 64), 1);

    // Minimum latency and address/data hold
    epoch++;
    start_dl(IDX);
    ce             = 1'b1;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd5;
    bus.ioctl_dout = 8'h3C;
    @(negedge clock);
    check_eq("lat_same_cycle", int'(mem_we), 0);
    step();
    bus.ioctl_wr = 1'b0;
    @(negedge clock);
    check_eq("lat_we", int'(mem_we), 1);
    check_eq("lat_addr", int'(mem_a), 5);
    check_eq("lat_data", int'(mem_d), 8'h3C);
    step();
    @(negedge clock);
    check_eq("hold_we", int'(mem_we), 0);
    check_eq("hold_addr", int'(mem_a), 5);
    check_eq("hold_data", int'(mem_d), 8'h3C);
    end_dl();
    check_eq("lat_done", int'(done), 1);

    // Other-index download while in DONE: nothing moves
    w0  = wcount;
    wt0 = wait_cyc;
    b0  = busy_cyc;
    for (int i = 0; i < 8; i++) file[i] = 8'($urandom);
    start_dl(IDX + 8'd1);
    send_file(8, 0, 1, 1'b0, 1'b0);
    check_eq("oidx_busy_mid", int'(busy), 0);
    end_dl();
    check_eq("oidx_wcount", wcount - w0, 0);
    check_eq("oidx_wait", wait_cyc - wt0, 0);
    check_eq("oidx_busy", busy_cyc - b0, 0);
    check_eq("oidx_done_kept", int'(done), 1);

    // Write past the end of the image
    epoch++;
    w0 = wcount;
    start_dl(IDX);
    ce             = 1'b1;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(NB);
    bus.ioctl_dout = 8'hA5;
    step();
    bus.ioctl_wr = 1'b0;
    end_dl();
    check_eq("ovf_wcount", wcount - w0, 0);
    check_eq("ovf_ram0", int'(stamp[0] == epoch), 0);
    check_eq("ovf_error", int'(error), 1);
    check_eq("ovf_done", int'(done), 0);

    // HPS ignores wait: second byte dropped, first still written
    epoch++;
    w0 = wcount;
    start_dl(IDX);
    ce             = 1'b0;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'h5A;
    step();
    bus.ioctl_addr = 25'd1;
    bus.ioctl_dout = 8'hC3;
    step();
    bus.ioctl_wr = 1'b0;
    check_eq("viol_wait", int'(bus.ioctl_wait), 1);
    end_dl();
    check_eq("viol_wcount", wcount - w0, 1);
    check_eq("viol_ram0", int'(stamp[0] == epoch && ram[0] == 8'h5A), 1);
    check_eq("viol_ram1", int'(stamp[1] == epoch), 0);
    check_eq("viol_error", int'(error), 1);
    check_eq("viol_done", int'(done), 0);

    // Reset with a byte parked in the buffer
    w0 = wcount;
    start_dl(IDX);
    ce             = 1'b0;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd2;
    bus.ioctl_dout = 8'h77;
    step();
    bus.ioctl_wr = 1'b0;
    check_eq("rstf_pre_wait", int'(bus.ioctl_wait), 1);
    reset              = 1'b1;
    ce                 = 1'b1;
    bus.ioctl_download = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    check_eq("rstf_wcount", wcount - w0, 0);
    check_eq("rstf_busy", int'(busy), 0);
    check_eq("rstf_done", int'(done), 0);
    check_eq("rstf_error", int'(error), 0);
    check_eq("rstf_wait", int'(bus.ioctl_wait), 0);

`ifdef ROM_LOADER_CKSUM_EN
    file[0] = 8'hFF;
    file[1] = 8'h02;
    file[2] = 8'h10;
    run_clean(3, 0, 1, 1'b0, 1'b0, "ck1");
    check_eq("ck1_value", int'(cksum), 8'h11);
    file[0] = 8'h05;
    run_clean(1, 0, 1, 1'b0, 1'b0, "ck2");
    check_eq("ck2_value", int'(cksum), 8'h05);
`endif

    // Random lengths, ce patterns and index noise after start
    for (int t = 0; t < 4; t++) begin
      int n;
      int mode;
      int p;
      n    = $urandom_range(1, 300);
      mode = $urandom_range(0, 2);
      p    = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) file[i] = 8'($urandom);
      run_clean(n, mode, p, 1'b1, 1'b1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
